// File: rtl/circle_pixel_buffer_pkg.sv
// Shared types and helpers for the FAST9 circle pixel buffer.
// Consumed by circle_bank and circle_pixel_buffer.
package fast_pkg;

    localparam int PIX_W_DEF  = 8;
    localparam int NUM_CIRCLE = 16;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } bank_state_t;

    // Slot 0 occupies the MSBs of the packed word.
    function automatic int unsigned slotLsb(input int unsigned idx,
                                            input int unsigned numPix,
                                            input int unsigned pixW);
        return (numPix - 1 - idx) * pixW;
    endfunction

    function automatic int unsigned popcount(input logic [63:0] v);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < 64; i++) begin
            if (v[i]) n++;
        end
        return n;
    endfunction

endpackage

// File: rtl/circle_pixel_buffer_bank.sv
// circle_bank: one set of circle slots plus centre, with fill bitmap and FILL/HOLD state.
// The done port exists only when DOUBLE_BUFFER_EN is defined.
module circle_bank
    import fast_pkg::*;
#(
    parameter int PIX_W   = PIX_W_DEF,
    parameter int NUM_PIX = NUM_CIRCLE,
    localparam int ADDR_W = $clog2(NUM_PIX),
    localparam int CNT_W  = $clog2(NUM_PIX + 1)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     wrEn,
    input  logic [ADDR_W-1:0]        wrAddr,
    input  logic [PIX_W-1:0]         wrData,
    input  logic                     centerEn,
    input  logic [PIX_W-1:0]         centerData,
    input  logic                     drain,
    output logic                     full,
`ifdef DOUBLE_BUFFER_EN
    output logic                     done,
`endif
    output logic [NUM_PIX*PIX_W-1:0] pixels,
    output logic [PIX_W-1:0]         center,
    output logic [CNT_W-1:0]         fillCount
);

    bank_state_t          state, stateNext;
    logic [PIX_W-1:0]     slots [NUM_PIX];
    logic [NUM_PIX-1:0]   bitmap, bitmapNext;
    logic                 centerValid, centerValidNext;
    logic                 complete;

    always_comb begin
        bitmapNext      = bitmap;
        centerValidNext = centerValid | centerEn;
        if (wrEn) bitmapNext[wrAddr] = 1'b1;
        // Completion looks at the post-write bitmap so HOLD is entered on the last write's edge.
        complete  = (state == FILL) && (&bitmapNext) && centerValidNext;
        stateNext = state;
        case (state)
            FILL:    if (complete) stateNext = HOLD;
            HOLD:    if (drain)    stateNext = FILL;
            default: stateNext = FILL;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= FILL;
            bitmap      <= '0;
            centerValid <= 1'b0;
            center      <= '0;
            for (int unsigned i = 0; i < NUM_PIX; i++) slots[i] <= '0;
        end else if (clear) begin
            state       <= FILL;
            bitmap      <= '0;
            centerValid <= 1'b0;
        end else begin
            state <= stateNext;
            if (state == HOLD && drain) begin
                bitmap      <= '0;
                centerValid <= 1'b0;
            end else begin
                bitmap      <= bitmapNext;
                centerValid <= centerValidNext;
            end
            if (wrEn)     slots[wrAddr] <= wrData;
            if (centerEn) center        <= centerData;
        end
    end

    always_comb begin
        pixels = '0;
        for (int unsigned i = 0; i < NUM_PIX; i++) begin
            pixels[slotLsb(i, NUM_PIX, PIX_W) +: PIX_W] = slots[i];
        end
    end

    assign full      = (state == HOLD);
    assign fillCount = CNT_W'(popcount(64'(bitmap)));
`ifdef DOUBLE_BUFFER_EN
    assign done      = complete;
`endif

endmodule

// File: rtl/circle_pixel_buffer.sv
// circle_pixel_buffer: collects FAST9 circle + centre pixels and presents them under valid/ready.
// Define DOUBLE_BUFFER_EN for ping-pong fill/output banks; otherwise a single bank is used.
module circle_pixel_buffer
    import fast_pkg::*;
#(
    parameter int PIX_W   = PIX_W_DEF,
    parameter int NUM_PIX = NUM_CIRCLE,
    localparam int ADDR_W = $clog2(NUM_PIX),
    localparam int CNT_W  = $clog2(NUM_PIX + 1)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     wrEn,
    input  logic [ADDR_W-1:0]        wrAddr,
    input  logic [PIX_W-1:0]         wrData,
    input  logic                     centerEn,
    input  logic [PIX_W-1:0]         centerData,
    output logic                     outValid,
    input  logic                     outReady,
    output logic [NUM_PIX*PIX_W-1:0] outPixels,
    output logic [PIX_W-1:0]         outCenter,
    output logic [CNT_W-1:0]         fillCount,
    output logic                     wrDrop
);

    localparam logic [ADDR_W:0] SLOT_LIMIT = (ADDR_W + 1)'(NUM_PIX);

    logic                     addrOk, fillFull, outFull;
    logic                     wrAccept, centerAccept, handshake;
    logic [NUM_PIX*PIX_W-1:0] outBankPixels;
    logic [PIX_W-1:0]         outBankCenter;

    assign addrOk       = {1'b0, wrAddr} < SLOT_LIMIT;
    assign wrAccept     = wrEn && addrOk && !fillFull && !clear;
    assign centerAccept = centerEn && !fillFull && !clear;
    assign handshake    = outFull && outReady;

`ifdef DOUBLE_BUFFER_EN
    logic                     fillSel, fillDone;
    logic                     bankFull   [2];
    logic                     bankDone   [2];
    logic [NUM_PIX*PIX_W-1:0] bankPixels [2];
    logic [PIX_W-1:0]         bankCenter [2];
    logic [CNT_W-1:0]         bankCount  [2];

    for (genvar b = 0; b < 2; b++) begin : gBank
        circle_bank #(.PIX_W(PIX_W), .NUM_PIX(NUM_PIX)) uBank (
            .clock      (clock),
            .reset      (reset),
            .clear      (clear),
            .wrEn       (wrAccept && (fillSel == 1'(b))),
            .wrAddr     (wrAddr),
            .wrData     (wrData),
            .centerEn   (centerAccept && (fillSel == 1'(b))),
            .centerData (centerData),
            .drain      (handshake && (fillSel != 1'(b))),
            .full       (bankFull[b]),
            .done       (bankDone[b]),
            .pixels     (bankPixels[b]),
            .center     (bankCenter[b]),
            .fillCount  (bankCount[b])
        );
    end

    assign fillFull      = bankFull[fillSel];
    assign fillDone      = bankDone[fillSel];
    assign outFull       = bankFull[!fillSel];
    assign outBankPixels = bankPixels[!fillSel];
    assign outBankCenter = bankCenter[!fillSel];
    assign fillCount     = bankCount[fillSel];

    // Swap whenever a complete fill bank can take over an output bank that is empty or draining now.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fillSel <= 1'b0;
        end else if (!clear && (fillFull || fillDone) && (!outFull || handshake)) begin
            fillSel <= !fillSel;
        end
    end
`else
    circle_bank #(.PIX_W(PIX_W), .NUM_PIX(NUM_PIX)) uBank (
        .clock      (clock),
        .reset      (reset),
        .clear      (clear),
        .wrEn       (wrAccept),
        .wrAddr     (wrAddr),
        .wrData     (wrData),
        .centerEn   (centerAccept),
        .centerData (centerData),
        .drain      (handshake),
        .full       (fillFull),
        .pixels     (outBankPixels),
        .center     (outBankCenter),
        .fillCount  (fillCount)
    );

    assign outFull = fillFull;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wrDrop <= 1'b0;
        end else begin
            wrDrop <= !clear && ((wrEn && (!addrOk || fillFull)) || (centerEn && fillFull));
        end
    end

    assign outValid  = outFull;
    assign outPixels = outFull ? outBankPixels : '0;
    assign outCenter = outFull ? outBankCenter : '0;

endmodule

// File: tb/tb_circle_pixel_buffer.sv
// Randomised scoreboard bench for circle_pixel_buffer, single or DOUBLE_BUFFER_EN build.
module tb_circle_pixel_buffer;

    localparam int PW = 8;
    localparam int NP = 16;
    localparam int W  = NP * PW;

    typedef logic [W+PW-1:0] set_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          clear = 1'b0;
    logic          wrEn = 1'b0;
    logic [3:0]    wrAddr = '0;
    logic [PW-1:0] wrData = '0;
    logic          centerEn = 1'b0;
    logic [PW-1:0] centerData = '0;
    logic          outReady = 1'b0;
    logic          outValid;
    logic [W-1:0]  outPixels;
    logic [PW-1:0] outCenter;
    logic [4:0]    fillCount;
    logic          wrDrop;

    int tests = 0;
    int fails = 0;

    // Reference model: contents of the set being filled, and whether a set is on the output.
    logic [PW-1:0] mSlots [NP];
    bit            mWritten [NP];
    bit            mCv;
    logic [PW-1:0] mCenter;
    bit            mFillFull;
    bit            mOutHeld;
    bit            mDrop;
    set_t          expQ [$];

    circle_pixel_buffer #(.PIX_W(PW), .NUM_PIX(NP)) dut (
        .clock      (clock),
        .reset      (reset),
        .clear      (clear),
        .wrEn       (wrEn),
        .wrAddr     (wrAddr),
        .wrData     (wrData),
        .centerEn   (centerEn),
        .centerData (centerData),
        .outValid   (outValid),
        .outReady   (outReady),
        .outPixels  (outPixels),
        .outCenter  (outCenter),
        .fillCount  (fillCount),
        .wrDrop     (wrDrop)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic set_t buildSet();
        set_t s = '0;
        for (int i = 0; i < NP; i++) s = (s << PW) | set_t'(mSlots[i]);
        return (s << PW) | set_t'(mCenter);
    endfunction

    function automatic int countWritten();
        int n = 0;
        for (int i = 0; i < NP; i++) n += mWritten[i] ? 1 : 0;
        return n;
    endfunction

    task automatic modelEmptyFill();
        for (int i = 0; i < NP; i++) mWritten[i] = 1'b0;
        mCv = 1'b0;
        mFillFull = 1'b0;
    endtask

    task automatic modelWrite(input bit we, input int addr, input logic [PW-1:0] d,
                              input bit ce, input logic [PW-1:0] cd);
        if (we && addr < NP) begin
            mSlots[addr]   = d;
            mWritten[addr] = 1'b1;
        end
        if (ce) begin
            mCenter = cd;
            mCv     = 1'b1;
        end
    endtask

    // One clock: check the DUT against the model, then drive inputs for the next edge.
    task automatic step(input bit clr, input bit we, input int addr, input logic [PW-1:0] d,
                        input bit ce, input logic [PW-1:0] cd, input bit rdy);
        bit busy, hs, complete;
        @(posedge clock);
        #1;
        chk("outValid", outValid, mOutHeld);
        if (!mOutHeld) begin
            chk("idle_pixels", outPixels, '0);
            chk("idle_center", outCenter, '0);
        end
        chk("fillCount", fillCount, countWritten());
        chk("wrDrop", wrDrop, mDrop);
        #1;
        clear = clr; wrEn = we; wrAddr = addr[3:0]; wrData = d;
        centerEn = ce; centerData = cd; outReady = rdy;
`ifdef DOUBLE_BUFFER_EN
        busy = mFillFull;
`else
        busy = mOutHeld;
`endif
        hs = mOutHeld && rdy;
        if (clr) begin
            modelEmptyFill();
            mOutHeld = 1'b0;
            mDrop = 1'b0;
        end else begin
            mDrop = (we && (addr >= NP || busy)) || (ce && busy);
`ifdef DOUBLE_BUFFER_EN
            if (!busy) modelWrite(we, addr, d, ce, cd);
            complete = busy || (countWritten() == NP && mCv);
            if (complete && (!mOutHeld || hs)) begin
                expQ.push_back(buildSet());
                mOutHeld = 1'b1;
                modelEmptyFill();
            end else begin
                if (hs) mOutHeld = 1'b0;
                mFillFull = complete;
            end
`else
            complete = 1'b0;
            if (hs) begin
                mOutHeld = 1'b0;
                modelEmptyFill();
            end else if (!mOutHeld) begin
                modelWrite(we, addr, d, ce, cd);
                complete = (countWritten() == NP && mCv);
                if (complete) begin
                    mOutHeld = 1'b1;
                    expQ.push_back(buildSet());
                end
            end
`endif
        end
    endtask

    // Monitor: every presented set must match the oldest expected one; retire it on handshake or clear.
    initial begin
        forever begin
            @(negedge clock);
            if (!reset && outValid) begin
                if (expQ.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL set_unexpected: got outValid=1 expected no pending set");
                end else begin
                    chk("set_data", {outPixels, outCenter}, expQ[0]);
                    if (outReady || clear) void'(expQ.pop_front());
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] t1Word;
        int           n;
        int           rdyPct [4];
        int           cenPct [4];
        int           clrPm  [4];
        bit           rWe, rCe, rRdy, rClr;
        int           rAd;

        for (int i = 0; i < NP; i++) begin
            mSlots[i] = '0;
            mWritten[i] = 1'b0;
        end
        mCv = 0; mCenter = '0; mFillFull = 0; mOutHeld = 0; mDrop = 0;

        #3;
        chk("rst_outValid", outValid, 1'b0);
        chk("rst_pixels", outPixels, '0);
        chk("rst_center", outCenter, '0);
        chk("rst_fillCount", fillCount, 5'd0);
        chk("rst_wrDrop", wrDrop, 1'b0);
        #9 reset = 1'b0;

        // Slots 15..0 with data addr*3, then the centre.
        t1Word = '0;
        for (int a = 0; a < NP; a++) t1Word = (t1Word << PW) | W'(a * 3);
        for (int a = NP - 1; a >= 0; a--) step(0, 1, a, 8'(a * 3), 0, 8'h00, 0);
        step(0, 0, 0, 8'h00, 1, 8'h80, 0);
        step(0, 0, 0, 8'h00, 0, 8'h00, 0);
        chk("t1_valid", outValid, 1'b1);
        chk("t1_slot0", outPixels[W-1 -: 8], 8'h00);
        chk("t1_slot15", outPixels[7:0], 8'h2D);
        chk("t1_center", outCenter, 8'h80);

        // Long hold, a write during hold, then handshake.
        repeat (9) step(0, 0, 0, 8'h00, 0, 8'h00, 0);
        step(0, 1, 3, 8'h55, 0, 8'h00, 0);
        step(0, 0, 0, 8'h00, 0, 8'h00, 0);
        chk("t3_stable", outPixels, t1Word);
        step(0, 0, 0, 8'h00, 0, 8'h00, 1);
        step(0, 0, 0, 8'h00, 0, 8'h00, 0);

        // Slot 5 written twice; fillCount tracking is checked every step.
        step(0, 1, 5, 8'h11, 0, 8'h00, 0);
        for (int a = 0; a < NP; a++) step(0, 1, a, (a == 5) ? 8'h22 : 8'(a + 8'h40), 0, 8'h00, 0);
        step(0, 0, 0, 8'h00, 1, 8'h7E, 0);
        step(0, 0, 0, 8'h00, 0, 8'h00, 0);
        chk("t2_slot5", outPixels[W-1-5*PW -: 8], 8'h22);
        step(0, 0, 0, 8'h00, 0, 8'h00, 1);
        step(0, 0, 0, 8'h00, 0, 8'h00, 0);

        // Clear at fillCount 9, then a full refill.
        for (int a = 0; a < 9; a++) step(0, 1, a, 8'(a + 8'h90), 0, 8'h00, 0);
        step(0, 0, 0, 8'h00, 0, 8'h00, 0);
        chk("t4_count9", fillCount, 5'd9);
        step(1, 1, 10, 8'hAA, 1, 8'h33, 0);
        step(0, 0, 0, 8'h00, 0, 8'h00, 0);
        chk("t4_cleared", fillCount, 5'd0);
        for (int a = 0; a < NP; a++) step(0, 1, a, 8'(8'hC0 - a), 0, 8'h00, 0);
        step(0, 0, 0, 8'h00, 1, 8'h21, 0);
        step(0, 0, 0, 8'h00, 0, 8'h00, 0);
        chk("t4_refill_valid", outValid, 1'b1);
        step(0, 0, 0, 8'h00, 0, 8'h00, 1);

        // Randomised phases with differing ready / centre / clear rates.
        rdyPct = '{90, 30, 60, 100};
        cenPct = '{10, 5, 20, 30};
        clrPm  = '{0, 5, 20, 2};
        for (int p = 0; p < 4; p++) begin
            for (int c = 0; c < 600; c++) begin
                rWe  = ($urandom % 100) < 75;
                rAd  = int'($urandom % NP);
                rCe  = ($urandom % 100) < cenPct[p];
                rRdy = ($urandom % 100) < rdyPct[p];
                rClr = ($urandom % 1000) < clrPm[p];
                step(rClr, rWe, rAd, 8'($urandom), rCe, 8'($urandom), rRdy);
            end
        end

        // Asynchronous reset while a set is presented.
        step(0, 0, 0, 8'h00, 0, 8'h00, 0);
        n = 0;
        while (outValid !== 1'b1 && n < 300) begin
            step(0, 1, int'($urandom % NP), 8'($urandom), 1, 8'($urandom), 0);
            n++;
        end
        chk("t5_reached_valid", outValid, 1'b1);
        @(posedge clock);
        #2;
        reset = 1'b1;
        clear = 0; wrEn = 0; centerEn = 0; outReady = 0;
        #1;
        chk("t5_outValid", outValid, 1'b0);
        chk("t5_pixels", outPixels, '0);
        chk("t5_center", outCenter, '0);
        chk("t5_fillCount", fillCount, 5'd0);
        expQ.delete();
        for (int i = 0; i < NP; i++) mSlots[i] = '0;
        modelEmptyFill();
        mCenter = '0; mOutHeld = 0; mDrop = 0;
        #3 reset = 1'b0;
        repeat (40) step(0, 1, int'($urandom % NP), 8'($urandom), ($urandom % 4) == 0,
                         8'($urandom), ($urandom % 2) == 0);
        step(0, 0, 0, 8'h00, 0, 8'h00, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
